// File: rtl/fx1_pipe.sv
// fx1_pipe -- simple-fixed-1 execution pipe of the SPU even pipeline.
//
// Purpose: computes a 128-bit FX1 result from the issued operands. The ops are
// word/halfword add, subtract, extended add/subtract, carry/borrow generate and
// the logicals. The result is delayed LATENCY cycles to the register-file
// writeback port. The pipe also exposes the in-flight destinations for issue
// hazard checks. A flush kills everything in flight, including the op being
// issued in the same cycle.
//
// Operand buses use big-endian bit order (bit 0 = MSB). Word slot i occupies
// bits [32i:32i+31], so word 0 is the most significant word.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   issue_valid/op          issue strobe and 4-bit op select
//   issue_ra/rb/rt          128-bit operands (rt supplies per-word carry-in)
//   issue_rt_addr           destination register
//   flush                   kill in-flight and same-cycle-issued ops
//   wb_valid/rt_addr/result writeback port (addr/result zero when not valid)
//   wb_illegal              unassigned op select, qualified by wb_valid
//   pipe_valid              per-stage valid, bit 0 = youngest
//   pipe_rt_addr            per-stage destination, stage 0 in LSBs (zero if invalid)
module fx1_pipe #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       issue_valid,
  input  logic [3:0]                 issue_op,
  input  logic [0:127]               issue_ra,
  input  logic [0:127]               issue_rb,
  input  logic [0:127]               issue_rt,
  input  logic [ADDR_W-1:0]          issue_rt_addr,
  input  logic                       flush,
  output logic                       wb_valid,
  output logic [ADDR_W-1:0]          wb_rt_addr,
  output logic [0:127]               wb_result,
  output logic                       wb_illegal,
  output logic [LATENCY-1:0]         pipe_valid,
  output logic [ADDR_W*LATENCY-1:0]  pipe_rt_addr
);

  localparam logic [3:0] OP_A    = 4'd0;
  localparam logic [3:0] OP_AH   = 4'd1;
  localparam logic [3:0] OP_SF   = 4'd2;
  localparam logic [3:0] OP_ADDX = 4'd3;
  localparam logic [3:0] OP_SFX  = 4'd4;
  localparam logic [3:0] OP_CG   = 4'd5;
  localparam logic [3:0] OP_BG   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;

  // Per-slot arithmetic. Each word is evaluated independently, so no carry
  // or borrow ever propagates from one slot into its neighbour.
  function automatic logic [0:127] fx1_alu(input logic [3:0]   op,
                                           input logic [0:127] ra,
                                           input logic [0:127] rb,
                                           input logic [0:127] rt);
    logic [0:127] r;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  w;
    logic [32:0]  s;
    logic [15:0]  hh;
    logic [15:0]  hl;
    logic         c;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a  = ra[32*i +: 32];
      b  = rb[32*i +: 32];
      c  = rt[32*i+31];
      s  = {1'b0, a} + {1'b0, b};
      hh = a[31:16] + b[31:16];
      hl = a[15:0] + b[15:0];
      w  = '0;
      case (op)
        OP_A:    w = s[31:0];
        OP_AH:   w = {hh, hl};
        OP_SF:   w = b - a;
        OP_ADDX: w = a + b + {31'd0, c};
        OP_SFX:  w = b + ~a + {31'd0, c};
        OP_CG:   w = {31'd0, s[32]};
        OP_BG:   w = {31'd0, (b >= a)};
        OP_AND:  w = a & b;
        OP_OR:   w = a | b;
        OP_XOR:  w = a ^ b;
        default: w = '0;
      endcase
      r[32*i +: 32] = w;
    end
    return r;
  endfunction

  logic [0:127] alu_res;
  logic         alu_ill;
  // Only the LSB of each rt word acts as a carry-in; the remaining bits are
  // folded here to mark them as deliberately ignored.
  logic         unused_rt;

  assign alu_res   = fx1_alu(issue_op, issue_ra, issue_rb, issue_rt);
  assign alu_ill   = (issue_op > OP_XOR);
  assign unused_rt = ^issue_rt;

  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] ill_p;
  logic [ADDR_W-1:0]  addr_p [LATENCY];
  logic [0:127]       res_p  [LATENCY];

  // ---- stage 0 capture and stage k -> k+1 shift: control (reset/flush) ----
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= issue_valid;
      for (int k = 1; k < LATENCY; k++) vld_p[k] <= vld_p[k-1];
    end
  end

  // ---- stage 0 capture and stage k -> k+1 shift: data (never reset) ----
  always_ff @(posedge clk) begin
    res_p[0]  <= alu_res;
    addr_p[0] <= issue_rt_addr;
    ill_p[0]  <= alu_ill;
    for (int k = 1; k < LATENCY; k++) begin
      res_p[k]  <= res_p[k-1];
      addr_p[k] <= addr_p[k-1];
      ill_p[k]  <= ill_p[k-1];
    end
  end

  // ---- writeback from stage LATENCY-1, data gated by its valid ----
  assign wb_valid   = vld_p[LATENCY-1];
  assign wb_result  = wb_valid ? res_p[LATENCY-1] : '0;
  assign wb_rt_addr = wb_valid ? addr_p[LATENCY-1] : '0;
  assign wb_illegal = wb_valid & ill_p[LATENCY-1];
  assign pipe_valid = vld_p;

  always_comb begin
    pipe_rt_addr = '0;
    for (int k = 0; k < LATENCY; k++)
      pipe_rt_addr[ADDR_W*k +: ADDR_W] = vld_p[k] ? addr_p[k] : '0;
  end

endmodule
